// File: rtl/vgs_pkg.sv
// Shared definitions for the VGS gate-drive path (PWM generator and vgs_controller).
package vgs_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SOFTSTART = 2'd1,
    S_RUN       = 2'd2,
    S_FAULT     = 2'd3
  } vgs_state_e;

  // VGS_MIN_ON is also the vgs_controller acceptance threshold.
  localparam int unsigned VGS_MIN_ON     = 3;
  localparam int unsigned VGS_MIN_PERIOD = 8;
  localparam int unsigned VGS_CLK_HZ     = 12_000_000;

endpackage

// File: rtl/vgs_pwm_ramp.sv
// Soft-start ramp: step counter and on-time register, built only with VGS_PWM_SOFT_START_EN.
module vgs_pwm_ramp
  import vgs_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MIN_ON       = VGS_MIN_ON,
  parameter int unsigned RAMP_PERIODS = 4,
  parameter int unsigned RAMP_STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_on_nxt
);

  localparam logic [CNT_W-1:0] C_MIN_ON = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] C_STEP   = CNT_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(RAMP_PERIODS - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_on;
  logic [CNT_W-1:0] r_steps;
  logic [CNT_W-1:0] w_steps_nxt;

  // o_on_nxt is the on-time of the period that starts at the coming edge.
  always_comb begin
    o_on_nxt    = r_on;
    w_steps_nxt = r_steps;
    if (i_start) begin
      o_on_nxt    = C_MIN_ON;
      w_steps_nxt = '0;
    end else if (i_step) begin
      if (r_steps >= C_LAST) begin
        w_steps_nxt = '0;
        o_on_nxt    = r_on + C_STEP;
      end else begin
        w_steps_nxt = r_steps + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on    <= '0;
      r_steps <= '0;
    end else begin
      r_on    <= o_on_nxt;
      r_steps <= w_steps_nxt;
    end
  end

endmodule

// File: rtl/vgs_pwm_generator.sv
// Fixed-frequency gate-drive PWM with double-buffered config, on-time clamping and latched fault.
// Optional soft-start ramp is built when VGS_PWM_SOFT_START_EN is defined.
module vgs_pwm_generator
  import vgs_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MIN_PERIOD   = VGS_MIN_PERIOD,
  parameter int unsigned MIN_ON       = VGS_MIN_ON,
  parameter int unsigned MAX_ON       = 100,
  parameter int unsigned RAMP_PERIODS = 4,
  parameter int unsigned RAMP_STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Enable,
  input  logic [CNT_W-1:0] PeriodCfg,
  input  logic [CNT_W-1:0] OnCfg,
  input  logic             CfgLoad,
  input  logic             Fault,
  output logic             PwmVGS,
  output logic             PeriodStart,
  output logic             Running,
  output logic             FaultLatched
);

  localparam logic [CNT_W-1:0] C_MIN_PERIOD = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] C_MIN_ON     = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] C_MAX_ON     = CNT_W'(MAX_ON);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  vgs_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_act_period, r_act_on;
  logic [CNT_W-1:0] r_pend_period, r_pend_on;
  logic             r_pend_vld;
  logic             w_load, w_wrap, w_run_nxt;
  logic [CNT_W-1:0] w_clamp_period, w_clamp_on;
  logic [CNT_W-1:0] w_tgt_nxt, w_on_eff_nxt;

  always_comb begin
    w_clamp_period = (r_pend_period < C_MIN_PERIOD) ? C_MIN_PERIOD : r_pend_period;
    w_clamp_on     = r_pend_on;
    if (w_clamp_on > C_MAX_ON)
      w_clamp_on = C_MAX_ON;
    if (w_clamp_on > w_clamp_period - C_ONE)
      w_clamp_on = w_clamp_period - C_ONE;
    if (w_clamp_on < C_MIN_ON)
      w_clamp_on = '0;
  end

  assign w_wrap = (r_cnt == r_act_period - C_ONE);

`ifdef VGS_PWM_SOFT_START_EN
  logic [CNT_W-1:0] w_ramp_nxt;
  logic             w_ramp_start, w_ramp_step;

  assign w_ramp_start = (r_state == S_IDLE) && Enable && !Fault;
  assign w_ramp_step  = (r_state == S_SOFTSTART) && w_wrap && Enable && !Fault;

  vgs_pwm_ramp #(
    .CNT_W       (CNT_W),
    .MIN_ON      (MIN_ON),
    .RAMP_PERIODS(RAMP_PERIODS),
    .RAMP_STEP   (RAMP_STEP)
  ) u_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_ramp_start),
    .i_step  (w_ramp_step),
    .o_on_nxt(w_ramp_nxt)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (Enable) begin
`ifdef VGS_PWM_SOFT_START_EN
          w_state_nxt = S_SOFTSTART;
`else
          w_state_nxt = S_RUN;
`endif
          w_load = r_pend_vld;
        end
      end
      S_SOFTSTART, S_RUN: begin
        if (!Enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_wrap) begin
          w_cnt_nxt = '0;
          w_load    = r_pend_vld;
`ifdef VGS_PWM_SOFT_START_EN
          if ((r_state == S_SOFTSTART) &&
              (w_ramp_nxt >= (r_pend_vld ? w_clamp_on : r_act_on)))
            w_state_nxt = S_RUN;
`endif
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_FAULT: begin
        w_cnt_nxt = '0;
        if (!Enable)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (Fault) begin
      w_state_nxt = S_FAULT;
      w_cnt_nxt   = '0;
      w_load      = 1'b0;
    end
  end

  assign w_tgt_nxt = w_load ? w_clamp_on : r_act_on;
  assign w_run_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_SOFTSTART);

  always_comb begin
    w_on_eff_nxt = w_tgt_nxt;
`ifdef VGS_PWM_SOFT_START_EN
    if ((w_state_nxt == S_SOFTSTART) && (w_ramp_nxt < w_tgt_nxt))
      w_on_eff_nxt = w_ramp_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_act_period  <= C_MIN_PERIOD;
      r_act_on      <= '0;
      r_pend_period <= C_MIN_PERIOD;
      r_pend_on     <= '0;
      r_pend_vld    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_act_period <= w_clamp_period;
        r_act_on     <= w_clamp_on;
      end
      // A load arriving on a boundary cycle stays pending for the following boundary.
      if (CfgLoad && !Fault) begin
        r_pend_period <= PeriodCfg;
        r_pend_on     <= OnCfg;
        r_pend_vld    <= 1'b1;
      end else if (w_load) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PwmVGS       <= 1'b0;
      PeriodStart  <= 1'b0;
      Running      <= 1'b0;
      FaultLatched <= 1'b0;
    end else begin
      PwmVGS       <= w_run_nxt && (w_cnt_nxt < w_on_eff_nxt);
      PeriodStart  <= w_run_nxt && (w_cnt_nxt == '0);
      Running      <= w_run_nxt;
      FaultLatched <= (w_state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_vgs_pwm_generator.sv
// Directed bench for vgs_pwm_generator: clamp table plus fault, double-buffer, soft-start and reset sequences.
module tb_vgs_pwm_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] PeriodCfg = '0;
  logic [15:0] OnCfg = '0;
  logic        CfgLoad = 1'b0;
  logic        Fault = 1'b0;
  logic        PwmVGS, PeriodStart, Running, FaultLatched;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned m_cnt = 0;

  typedef struct {
    int unsigned per_cfg;
    int unsigned on_cfg;
    int unsigned exp_per;
    int unsigned exp_on;
  } vec_t;

  vgs_pwm_generator #(
    .CNT_W(16), .MIN_PERIOD(8), .MIN_ON(3), .MAX_ON(100), .RAMP_PERIODS(4), .RAMP_STEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable), .PeriodCfg(PeriodCfg), .OnCfg(OnCfg),
    .CfgLoad(CfgLoad), .Fault(Fault), .PwmVGS(PwmVGS), .PeriodStart(PeriodStart),
    .Running(Running), .FaultLatched(FaultLatched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic pwm, input logic ps, input logic run, input logic flt);
    chk({tag, ".pwm"}, PwmVGS, pwm);
    chk({tag, ".ps"}, PeriodStart, ps);
    chk({tag, ".run"}, Running, run);
    chk({tag, ".flt"}, FaultLatched, flt);
  endtask

  // One negedge per cycle; model counter m_cnt tracks the expected period position.
  task automatic run_check(input int unsigned n, input int unsigned per, input int unsigned on,
                           input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk_all(tag, m_cnt < on, m_cnt == 0, 1'b1, 1'b0);
      m_cnt = (m_cnt + 1 == per) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic idle_check(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic load_cfg(input int unsigned p, input int unsigned o);
    PeriodCfg = 16'(p);
    OnCfg     = 16'(o);
    CfgLoad   = 1'b1;
    @(negedge clk);
    CfgLoad   = 1'b0;
    chk_all("load_idle", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_run();
    Enable = 1'b1;
    m_cnt  = 0;
  endtask

  initial begin
    vec_t vecs[6];
    int unsigned last_per, last_on;
    vecs[0] = '{120, 40, 120, 40};
    vecs[1] = '{120, 2, 120, 0};
    vecs[2] = '{120, 500, 120, 100};
    vecs[3] = '{3, 5, 8, 5};
    vecs[4] = '{4, 20, 8, 7};
    vecs[5] = '{20, 3, 20, 3};

    // Reset state.
    @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(3, "idle_after_reset");

`ifndef VGS_PWM_SOFT_START_EN
    foreach (vecs[v]) begin
      load_cfg(vecs[v].per_cfg, vecs[v].on_cfg);
      start_run();
      run_check(2 * vecs[v].exp_per + 5, vecs[v].exp_per, vecs[v].exp_on, $sformatf("vec%0d", v));
      Enable = 1'b0;
      @(negedge clk);
      chk_all($sformatf("vec%0d_trunc", v), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Fault mid-pulse, sticky while Enable is high, cleared via Enable=0.
    load_cfg(120, 40);
    start_run();
    run_check(10, 120, 40, "pre_fault");
    Fault = 1'b1;
    @(negedge clk);
    chk_all("fault_hit", 1'b0, 1'b0, 1'b0, 1'b1);
    Fault = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all("fault_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    Enable = 1'b0;
    @(negedge clk);
    chk_all("fault_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    start_run();
    run_check(120, 120, 40, "restart");

    // Double buffer: two loads inside one period, last one wins at the boundary.
    run_check(10, 120, 40, "db_a");
    PeriodCfg = 16'd60; OnCfg = 16'd20; CfgLoad = 1'b1;
    run_check(1, 120, 40, "db_b");
    CfgLoad = 1'b0;
    run_check(39, 120, 40, "db_c");
    PeriodCfg = 16'd60; OnCfg = 16'd30; CfgLoad = 1'b1;
    run_check(1, 120, 40, "db_d");
    CfgLoad = 1'b0;
    run_check(69, 120, 40, "db_e");
    run_check(120, 60, 30, "db_new");
    last_per = 60;
    last_on  = 30;
`else
    // Soft-start: on_eff 3,3,3,3,4,4,4,4,5,5,5,5,6...
    load_cfg(60, 6);
    start_run();
    for (int unsigned p = 0; p < 16; p++)
      run_check(60, 60, (3 + p / 4 < 6) ? 3 + p / 4 : 6, $sformatf("ss_p%0d", p));
    last_per = 60;
    last_on  = 6;
`endif

    // Asynchronous reset in the middle of a pulse.
    run_check(2, last_per, last_on, "pre_reset");
    rst_n  = 1'b0;
    Enable = 1'b0;
    #1;
    chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check(2, "in_reset");
    rst_n = 1'b1;
    idle_check(4, "idle_post_reset");
    start_run();
    run_check(16, 8, 0, "reset_defaults");
    Enable = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
